// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// drives the IF/ID load/flush controls, including bubbles, squashes and HLT stop.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] IF_instr,
    output logic [15:0] IF_PC_nxt,
    output logic        IF_ID_en,
    output logic        IF_ID_flush,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] redir_q, redir_d;
    logic [15:0] pc_inc_s;

    logic        req_s, en_s, flush_s, halted_s;
    logic [15:0] instr_s;

    function automatic logic is_hlt(input logic [15:0] instr);
        return (instr[15:12] == HLT_OPCODE);
    endfunction

    assign pc_inc_s = pc_q + 16'd2;

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= 16'h0000;
            redir_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            redir_q <= redir_d;
        end
    end

    // Next-state and combinational IF/ID controls.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        redir_d  = redir_q;
        req_s    = 1'b0;
        en_s     = 1'b0;
        flush_s  = 1'b0;
        instr_s  = 16'h0000;
        halted_s = (state_q == S_HALT);

        if ((state_q == S_FETCH) || (state_q == S_DRAIN)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end

        if (branch_taken) begin
            en_s    = 1'b1;
            flush_s = 1'b1;
            // A still-pending request must complete before the redirect takes effect.
            if (((state_q == S_FETCH) || (state_q == S_DRAIN)) && !imem_valid) begin
                redir_d = branch_target;
                state_d = S_DRAIN;
            end else begin
                pc_d    = branch_target;
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        if (!stall) begin
                            instr_s = imem_rdata;
                            en_s    = 1'b1;
                            if (is_hlt(imem_rdata)) begin
                                state_d = S_HALT;
                            end else begin
                                pc_d = pc_inc_s;
                            end
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end else begin
                        en_s    = !stall;
                        flush_s = !stall;
                    end
                end
                S_HOLD: begin
                    instr_s = hold_q;
                    if (!stall) begin
                        en_s = 1'b1;
                        if (is_hlt(hold_q)) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_inc_s;
                            state_d = S_FETCH;
                        end
                    end else begin
                        en_s = 1'b0;
                    end
                end
                S_DRAIN: begin
                    en_s    = !stall;
                    flush_s = !stall;
                    if (imem_valid) begin
                        pc_d    = redir_q;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_HALT: begin
                    en_s    = !stall;
                    flush_s = !stall;
                end
                default: begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
                end
            endcase
        end
    end

    // Outputs are forced to their reset values while rst_n is low, independent of inputs.
    assign imem_req    = rst_n & req_s;
    assign imem_addr   = pc_q;
    assign IF_ID_en    = rst_n & en_s;
    assign IF_ID_flush = rst_n & flush_s;
    assign IF_instr    = rst_n ? instr_s : 16'h0000;
    assign IF_PC_nxt   = pc_inc_s;
    assign pc          = pc_q;
    assign halted      = rst_n & halted_s;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: linear stimulus with hand-computed expectations.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] IF_instr;
    logic [15:0] IF_PC_nxt;
    logic        IF_ID_en;
    logic        IF_ID_flush;
    logic [15:0] pc;
    logic        halted;

    int vectors;
    int miscompares;

    if_fetch_unit #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .IF_instr      (IF_instr),
        .IF_PC_nxt     (IF_PC_nxt),
        .IF_ID_en      (IF_ID_en),
        .IF_ID_flush   (IF_ID_flush),
        .pc            (pc),
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_rdata    = 16'h0000;
        imem_valid    = 1'b0;

        // Reset values
        #2;
        chk("rst_req",    {15'd0, imem_req},    16'h0000);
        chk("rst_en",     {15'd0, IF_ID_en},    16'h0000);
        chk("rst_flush",  {15'd0, IF_ID_flush}, 16'h0000);
        chk("rst_instr",  IF_instr,             16'h0000);
        chk("rst_halted", {15'd0, halted},      16'h0000);
        chk("rst_pc",     pc,                   16'h0000);
        chk("rst_pcnxt",  IF_PC_nxt,            16'h0002);
        tick();

        // Zero-wait sequential fetch
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 16'h1100 + 16'(i);
            #1;
            chk("zw_req",   {15'd0, imem_req},    16'h0001);
            chk("zw_addr",  imem_addr,            16'(2 * i));
            chk("zw_pcnxt", IF_PC_nxt,            16'(2 * i + 2));
            chk("zw_en",    {15'd0, IF_ID_en},    16'h0001);
            chk("zw_flush", {15'd0, IF_ID_flush}, 16'h0000);
            chk("zw_instr", IF_instr,             16'h1100 + 16'(i));
            tick();
        end

        // Wait states: two bubbles then the instruction
        imem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ws_en",    {15'd0, IF_ID_en},    16'h0001);
            chk("ws_flush", {15'd0, IF_ID_flush}, 16'h0001);
            chk("ws_instr", IF_instr,             16'h0000);
            chk("ws_pc",    pc,                   16'h0008);
            tick();
        end
        imem_valid = 1'b1;
        imem_rdata = 16'h2222;
        #1;
        chk("ws_dlv_en",    {15'd0, IF_ID_en},    16'h0001);
        chk("ws_dlv_flush", {15'd0, IF_ID_flush}, 16'h0000);
        chk("ws_dlv_instr", IF_instr,             16'h2222);
        tick();
        chk("ws_pc_adv", pc, 16'h000A);

        // Stall during delivery of 16'h1234
        stall      = 1'b1;
        imem_rdata = 16'h1234;
        #1;
        chk("st_en0", {15'd0, IF_ID_en}, 16'h0000);
        tick();
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("st_en",  {15'd0, IF_ID_en}, 16'h0000);
            chk("st_req", {15'd0, imem_req}, 16'h0000);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("st_dlv_en",    {15'd0, IF_ID_en},    16'h0001);
        chk("st_dlv_flush", {15'd0, IF_ID_flush}, 16'h0000);
        chk("st_dlv_instr", IF_instr,             16'h1234);
        chk("st_dlv_req",   {15'd0, imem_req},    16'h0000);
        chk("st_dlv_pcnxt", IF_PC_nxt,            16'h000C);
        tick();
        chk("st_next_req",  {15'd0, imem_req}, 16'h0001);
        chk("st_next_addr", imem_addr,         16'h000C);

        // Advance to pc=0x10 then branch with the request outstanding
        imem_valid = 1'b1;
        imem_rdata = 16'h3333;
        tick();
        tick();
        imem_valid    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        #1;
        chk("br_en",    {15'd0, IF_ID_en},    16'h0001);
        chk("br_flush", {15'd0, IF_ID_flush}, 16'h0001);
        chk("br_addr",  imem_addr,            16'h0010);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("dr_req",   {15'd0, imem_req},    16'h0001);
        chk("dr_addr",  imem_addr,            16'h0010);
        chk("dr_flush", {15'd0, IF_ID_flush}, 16'h0001);
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'h5555;
        #1;
        chk("dr_drop_instr", IF_instr,             16'h0000);
        chk("dr_drop_flush", {15'd0, IF_ID_flush}, 16'h0001);
        chk("dr_drop_addr",  imem_addr,            16'h0010);
        tick();
        imem_valid = 1'b0;
        #1;
        chk("dr_new_addr", imem_addr,         16'h0040);
        chk("dr_new_req",  {15'd0, imem_req}, 16'h0001);

        // Redirect to 0x0008 with data arriving in the branch cycle (discarded)
        imem_valid    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0008;
        #1;
        chk("br2_instr", IF_instr,             16'h0000);
        chk("br2_flush", {15'd0, IF_ID_flush}, 16'h0001);
        tick();
        branch_taken = 1'b0;
        imem_rdata   = 16'hF000;
        #1;
        chk("hlt_addr",  imem_addr,            16'h0008);
        chk("hlt_instr", IF_instr,             16'hF000);
        chk("hlt_en",    {15'd0, IF_ID_en},    16'h0001);
        chk("hlt_flush", {15'd0, IF_ID_flush}, 16'h0000);
        chk("hlt_pcnxt", IF_PC_nxt,            16'h000A);
        tick();
        imem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("halt_halted", {15'd0, halted},      16'h0001);
            chk("halt_req",    {15'd0, imem_req},    16'h0000);
            chk("halt_en",     {15'd0, IF_ID_en},    16'h0001);
            chk("halt_flush",  {15'd0, IF_ID_flush}, 16'h0001);
            chk("halt_pc",     pc,                   16'h0008);
            tick();
        end
        branch_taken  = 1'b1;
        branch_target = 16'h0020;
        #1;
        chk("halt_br_flush", {15'd0, IF_ID_flush}, 16'h0001);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("unhalt_halted", {15'd0, halted},   16'h0000);
        chk("unhalt_req",    {15'd0, imem_req}, 16'h0001);
        chk("unhalt_addr",   imem_addr,         16'h0020);

        // Wrap-around at 0xFFFE
        imem_valid    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        imem_rdata   = 16'h1111;
        #1;
        chk("wrap_addr",  imem_addr, 16'hFFFE);
        chk("wrap_pcnxt", IF_PC_nxt, 16'h0000);
        chk("wrap_instr", IF_instr,  16'h1111);
        tick();
        imem_valid = 1'b0;
        #1;
        chk("wrap_next_addr", imem_addr, 16'h0000);

        // Async reset mid-DRAIN
        branch_taken  = 1'b1;
        branch_target = 16'h0080;
        tick();
        branch_taken = 1'b0;
        #1;
        chk("ar_drain_req", {15'd0, imem_req}, 16'h0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_req",    {15'd0, imem_req},    16'h0000);
        chk("ar_en",     {15'd0, IF_ID_en},    16'h0000);
        chk("ar_flush",  {15'd0, IF_ID_flush}, 16'h0000);
        chk("ar_instr",  IF_instr,             16'h0000);
        chk("ar_halted", {15'd0, halted},      16'h0000);
        chk("ar_pc",     pc,                   16'h0000);
        chk("ar_pcnxt",  IF_PC_nxt,            16'h0002);
        tick();
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'h4321;
        #1;
        chk("ar_post_req",   {15'd0, imem_req}, 16'h0001);
        chk("ar_post_addr",  imem_addr,         16'h0000);
        chk("ar_post_instr", IF_instr,          16'h4321);
        tick();
        chk("ar_post_pc", pc, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that feeds the IF/ID pipeline register. It owns the program counter and issues requests to instruction memory over a req/valid handshake. It delivers `IF_instr` and `IF_PC_nxt` together with the `IF_ID_en` and `IF_ID_flush` controls, and inserts bubbles on memory wait states and squashes on taken-branch redirects. It also stops fetching after a HLT instruction.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HLT_OPCODE`, 4'hF, value of `instr[15:12]` that identifies HLT.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hazard unit hold request; IF/ID must not load.
- `branch_taken`  in  1  redirect request from branch resolution; wins over everything.
- `branch_target`  in  16  redirect PC, sampled when `branch_taken`=1.
- `imem_req`  out  1  memory request; address held stable until `imem_valid`.
- `imem_addr`  out  16  fetch address.
- `imem_rdata`  in  16  instruction data, valid only with `imem_valid`.
- `imem_valid`  in  1  response strobe; may arrive in the same cycle as `imem_req` or any later cycle.
- `IF_instr`  out  16  instruction to IF/ID.
- `IF_PC_nxt`  out  16  PC+2 of the delivered instruction.
- `IF_ID_en`  out  1  IF/ID load enable.
- `IF_ID_flush`  out  1  IF/ID clear; only meaningful with `IF_ID_en`.
- `pc`  out  16  current fetch PC, for debug.
- `halted`  out  1  high while in HALT.

## Operation
The block has four states: FETCH, HOLD, DRAIN and HALT. Reset places it in FETCH with `pc`=RESET_PC. Reset mid-operation abandons any outstanding request without waiting for `imem_valid`.

Register contents:
- `pc`: address of the instruction being fetched.
- `hold_buf`: 16 bits, holds an instruction captured during a stall.
- `redir_pc`: 16 bits, holds the pending target while in DRAIN.

FETCH:
- `imem_req`=1, `imem_addr`=`pc`.
- `imem_valid` & ~`stall`: drive `IF_instr`=`imem_rdata`, `IF_ID_en`=1, `IF_ID_flush`=0; `pc`<=`pc`+2.
- `imem_valid` & `stall`: `hold_buf`<=`imem_rdata`; go to HOLD; `IF_ID_en`=0.
- ~`imem_valid` & ~`stall`: bubble, `IF_ID_en`=1, `IF_ID_flush`=1.
- ~`imem_valid` & `stall`: `IF_ID_en`=0.
- If the delivered instruction has `[15:12]`==HLT_OPCODE: go to HALT after delivery; `pc` is not incremented.

HOLD:
- `imem_req`=0, `IF_instr`=`hold_buf`.
- On ~`stall`: `IF_ID_en`=1, `pc`<=`pc`+2, return to FETCH (or go to HALT if `hold_buf` is HLT).

HALT:
- `imem_req`=0, `halted`=1, `pc` frozen.
- Each non-stalled cycle emits a bubble (`IF_ID_en`=1, `IF_ID_flush`=1).
- Only `branch_taken` or reset leaves HALT.

`branch_taken`, in any state:
- Same cycle: `IF_ID_en`=1 and `IF_ID_flush`=1, regardless of `stall`. Any `imem_rdata` returned in that cycle is discarded.
- FETCH with `imem_valid`=0 (request still outstanding): `redir_pc`<=`branch_target`, go to DRAIN.
- Otherwise: `pc`<=`branch_target`, go to FETCH.

DRAIN:
- `imem_req`=1 and `imem_addr` keeps the old `pc` until `imem_valid` arrives; that data is dropped.
- Then `pc`<=`redir_pc` and the block goes to FETCH.
- Bubbles are emitted while ~`stall`.
- A new `branch_taken` in DRAIN overwrites `redir_pc`.

Arithmetic: `IF_PC_nxt` = `pc`+2, 16-bit modulo, so 16'hFFFE wraps to 16'h0000. When no instruction is delivered, `IF_instr`=16'h0000.

## Timing
- Reset values (`rst_n` low): `imem_req`=0, `IF_ID_en`=0, `IF_ID_flush`=0, `IF_instr`=0, `halted`=0, `pc`=RESET_PC, `IF_PC_nxt`=RESET_PC+2.
- The first `imem_req` is asserted in the first cycle after `rst_n` rises.
- With zero-wait memory (`imem_valid` in the request cycle), throughput is one instruction per cycle.
- Latency is `imem_valid` arrival to IF/ID load on the same edge, with no extra register stage.
- `IF_ID_en`, `IF_ID_flush` and `IF_instr` are combinational from state and inputs. `pc` updates on the rising edge.
- HOLD-to-FETCH costs zero bubble cycles: the buffered instruction is delivered on the first non-stalled cycle, and the next request issues the following cycle.
- DRAIN costs N+1 cycles, where N is the remaining memory latency.

## Test plan
- **Zero-wait sequential fetch:** reset with RESET_PC=0, `imem_valid` tied 1 → `imem_addr` 0,2,4,6 on consecutive cycles; `IF_PC_nxt` 2,4,6,8; `IF_ID_en`=1 and `IF_ID_flush`=0 every cycle.
- **Wait states:** valid arrives 2 cycles after each request → two bubble cycles (en=1, flush=1), then the instruction; `pc` advances only on valid.
- **Stall during delivery:** `stall` high for 3 cycles on `imem_rdata`=16'h1234 → `IF_ID_en`=0 for 3 cycles, `imem_req`=0; then 16'h1234 delivered with en=1, and the next request is to `pc`+2.
- **Branch with an outstanding request:** request at 16'h0010 is pending, `branch_taken` with target 16'h0040 → flush in that cycle; `imem_addr` stays 16'h0010 until valid; its data is dropped; the next request is to 16'h0040.
- **HLT then redirect:** fetch 16'hF000 at 16'h0008 → HLT delivered, then `halted`=1, `imem_req`=0, bubbles each cycle. `branch_taken` with target 16'h0020 → FETCH at 16'h0020, `halted`=0.
- **Wrap-around and async reset:** `pc`=16'hFFFE → `IF_PC_nxt`=16'h0000 and the next fetch is at 16'h0000. Dropping `rst_n` mid-DRAIN → outputs return immediately to reset values without waiting for an edge.
